uart_frame_decoder: RTL
=======================

Name: uart_frame_decoder

Overview:
- Sits directly downstream of the UART receiver; consumes its one-cycle byte strobe and byte.
- Parses framed commands: SOF, CMD, LEN, LEN payload bytes, XOR checksum.
- Buffers the payload in an internal array and presents a validated frame to the command layer with a valid/ack handshake.
- Reports checksum, length and inter-byte timeout errors as single-cycle pulses.

Parameters:
- SOF_BYTE, 8'hA5, start-of-frame marker.
- MAX_LEN, 16, maximum payload bytes (1..255).
- TIMEOUT_CLKS, 10000, max clocks between bytes inside a frame before abort.

Ports:
- i_Clock  in  1  system clock.
- i_Reset  in  1  synchronous, active-high reset.
- i_Rx_DV  in  1  one-cycle strobe: i_Rx_Byte valid.
- i_Rx_Byte  in  8  received byte.
- o_Frame_Valid  out  1  validated frame pending; held until acked.
- o_Frame_Cmd  out  8  CMD of pending frame.
- o_Frame_Len  out  8  LEN of pending frame.
- i_Frame_Ack  in  1  one-cycle strobe: consumer done, release buffer.
- i_Rd_Addr  in  $clog2(MAX_LEN)  payload read index.
- o_Rd_Data  out  8  payload byte, registered.
- o_Err_Checksum  out  1  pulse: checksum mismatch.
- o_Err_Length  out  1  pulse: LEN > MAX_LEN.
- o_Err_Timeout  out  1  pulse: inter-byte timeout mid-frame.
- o_Overrun  out  1  pulse: byte dropped while frame pending.

Behaviour:
- One clock domain: i_Clock. Reset is synchronous and active-high.
- Reset values:
  - All outputs 0; state S_HUNT; checksum accumulator, index and timeout counter 0.
  - Payload array contents are don't-care.
  - Reset mid-frame or while pending discards everything; no error pulse.
- Checksum: chk = CMD ^ LEN ^ payload[0] ^ ... ^ payload[LEN-1]. The frame is good when the received checksum byte equals chk.
- States (all transitions occur only on i_Rx_DV unless noted):
  - S_HUNT: byte == SOF_BYTE -> S_CMD. Any other byte is ignored silently.
  - S_CMD: latch CMD, chk <= byte -> S_LEN.
  - S_LEN:
    - byte > MAX_LEN -> pulse o_Err_Length, go to S_HUNT.
    - Otherwise latch LEN, chk ^= byte, idx <= 0.
    - LEN == 0 -> S_CHK; else -> S_PAYLOAD.
  - S_PAYLOAD: store byte at payload[idx], chk ^= byte, idx++. When idx == LEN-1 before the increment -> S_CHK.
  - S_CHK:
    - Match -> S_HOLD, with o_Frame_Valid = 1 on the next cycle.
    - Mismatch -> pulse o_Err_Checksum, go to S_HUNT.
  - S_HOLD:
    - o_Frame_Valid, o_Frame_Cmd and o_Frame_Len are held stable.
    - i_Frame_Ack -> S_HUNT, and o_Frame_Valid drops on the next cycle.
    - i_Rx_DV without ack: byte dropped, o_Overrun pulses.
    - i_Rx_DV and i_Frame_Ack in the same cycle: the byte is evaluated as if in S_HUNT. SOF goes to S_CMD; any other byte is ignored. No overrun.
- Timeout:
  - In S_CMD, S_LEN, S_PAYLOAD and S_CHK, the counter clears on every i_Rx_DV and increments otherwise.
  - When the counter reaches TIMEOUT_CLKS-1 with no byte that cycle: pulse o_Err_Timeout, go to S_HUNT.
  - The counter is idle (0) in S_HUNT and S_HOLD.
- Error pulses last exactly one cycle and are registered. Only one error pulse can fire per cycle.
- Payload read:
  - o_Rd_Data <= payload[i_Rd_Addr] every cycle, so there is 1-cycle read latency.
  - Data is guaranteed only while o_Frame_Valid = 1.
  - Addresses >= LEN return don't-care.
- Throughput: accepts one byte per clock; no back-pressure on the byte input.

Decomposition:
- Shared package uart_frame_pkg:
  - State encoding constants S_HUNT..S_HOLD.
  - Default SOF value.
  - The checksum function, so the planned transmit-side encoder can reuse it.
- One natural sub-module: frame_payload_ram, a MAX_LEN x 8 array with a single write port and a registered read port.

Test Plan:
- Bytes A5, 10, 02, 33, 44, checksum 65 -> next cycle o_Frame_Valid = 1, Cmd = 10, Len = 2. Rd_Addr 0 gives 33 and Rd_Addr 1 gives 44, each 1 cycle later. Ack drops Valid next cycle.
- Bytes A5, 07, 00, checksum 07 (LEN = 0) -> Valid with Cmd = 07, Len = 0. Bytes A5, 07, 00, 08 -> o_Err_Checksum single pulse, Valid stays 0.
- Bytes A5, 01, 11 with MAX_LEN = 16 -> o_Err_Length pulse right after the LEN byte. A following valid frame decodes correctly.
- Bytes A5, 10, 02, 33, then silence for TIMEOUT_CLKS -> o_Err_Timeout pulse exactly TIMEOUT_CLKS cycles after the 33 strobe. Subsequent bytes are ignored until the next A5.
- Frame pending, byte 55 arrives without ack -> o_Overrun pulse, Valid held. Then A5 coincident with Ack -> no overrun, decoder in S_CMD; the next frame decodes.
- i_Reset asserted mid-payload, then a full valid frame -> no error pulses, and the frame decodes with correct payload.

Source files
------------

// File: rtl/uart_frame_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_frame_pkg: shared states, SOF default and checksum helper for   |
// | the UART command framing layer.                                      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package uart_frame_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        S_HUNT    = 3'd0,
        S_CMD     = 3'd1,
        S_LEN     = 3'd2,
        S_PAYLOAD = 3'd3,
        S_CHK     = 3'd4,
        S_HOLD    = 3'd5
    } frame_state_t;

    // Running XOR over CMD, LEN and payload; the encoder folds bytes the same way.
    function automatic logic [7:0] frame_checksum_step(
        input logic [7:0] acc,
        input logic [7:0] data
    );
        return acc ^ data;
    endfunction

endpackage : uart_frame_pkg
`default_nettype wire

// File: rtl/frame_payload_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_payload_ram: DEPTH x 8 payload buffer, one write port and a    |
// | registered read port.                                                |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module frame_payload_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] r_mem [DEPTH];

    // Array contents are never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= 8'h00;
        end else begin
            rd_data <= r_mem[rd_addr];
        end
    end

endmodule : frame_payload_ram
`default_nettype wire

// File: rtl/uart_frame_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_frame_decoder: parses SOF/CMD/LEN/payload/XOR frames from the   |
// | UART byte strobe and holds a validated frame until acknowledged.     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE     = SOF_DEFAULT,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 10000,
    localparam int        ADDR_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    input  logic              i_Rx_DV,
    input  logic [7:0]        i_Rx_Byte,
    output logic              o_Frame_Valid,
    output logic [7:0]        o_Frame_Cmd,
    output logic [7:0]        o_Frame_Len,
    input  logic              i_Frame_Ack,
    input  logic [ADDR_W-1:0] i_Rd_Addr,
    output logic [7:0]        o_Rd_Data,
    output logic              o_Err_Checksum,
    output logic              o_Err_Length,
    output logic              o_Err_Timeout,
    output logic              o_Overrun
);

    localparam int         CNT_W     = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CLKS - 1);

    frame_state_t     r_state, w_next_state;
    logic [7:0]       r_cmd, w_cmd;
    logic [7:0]       r_len, w_len;
    logic [7:0]       r_chk, w_chk;
    logic [7:0]       r_idx, w_idx;
    logic [CNT_W-1:0] r_tcnt, w_tcnt;
    logic             r_valid;
    logic             r_err_chk, r_err_len, r_err_to, r_overrun;
    logic             w_err_chk, w_err_len, w_err_to, w_overrun;
    logic             w_wr_en;
    logic             w_in_frame;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state   <= S_HUNT;
            r_cmd     <= 8'h00;
            r_len     <= 8'h00;
            r_chk     <= 8'h00;
            r_idx     <= 8'h00;
            r_tcnt    <= '0;
            r_valid   <= 1'b0;
            r_err_chk <= 1'b0;
            r_err_len <= 1'b0;
            r_err_to  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cmd     <= w_cmd;
            r_len     <= w_len;
            r_chk     <= w_chk;
            r_idx     <= w_idx;
            r_tcnt    <= w_tcnt;
            r_valid   <= (w_next_state == S_HOLD);
            r_err_chk <= w_err_chk;
            r_err_len <= w_err_len;
            r_err_to  <= w_err_to;
            r_overrun <= w_overrun;
        end
    end

    assign w_in_frame = (r_state == S_CMD) || (r_state == S_LEN) ||
                        (r_state == S_PAYLOAD) || (r_state == S_CHK);

    always_comb begin
        w_next_state = r_state;
        w_cmd        = r_cmd;
        w_len        = r_len;
        w_chk        = r_chk;
        w_idx        = r_idx;
        w_tcnt       = '0;
        w_err_chk    = 1'b0;
        w_err_len    = 1'b0;
        w_err_to     = 1'b0;
        w_overrun    = 1'b0;
        w_wr_en      = 1'b0;

        case (r_state)
            S_HUNT: begin
                if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) begin
                    w_next_state = S_CMD;
                end
            end
            S_CMD: begin
                if (i_Rx_DV) begin
                    w_cmd        = i_Rx_Byte;
                    w_chk        = frame_checksum_step(8'h00, i_Rx_Byte);
                    w_next_state = S_LEN;
                end
            end
            S_LEN: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte > MAX_LEN_B) begin
                        w_err_len    = 1'b1;
                        w_next_state = S_HUNT;
                    end else begin
                        w_len        = i_Rx_Byte;
                        w_chk        = frame_checksum_step(r_chk, i_Rx_Byte);
                        w_idx        = 8'h00;
                        w_next_state = (i_Rx_Byte == 8'h00) ? S_CHK : S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (i_Rx_DV) begin
                    w_wr_en = 1'b1;
                    w_chk   = frame_checksum_step(r_chk, i_Rx_Byte);
                    w_idx   = r_idx + 8'd1;
                    if (r_idx == (r_len - 8'd1)) begin
                        w_next_state = S_CHK;
                    end
                end
            end
            S_CHK: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == r_chk) begin
                        w_next_state = S_HOLD;
                    end else begin
                        w_err_chk    = 1'b1;
                        w_next_state = S_HUNT;
                    end
                end
            end
            S_HOLD: begin
                // A byte arriving with the ack is treated as the first byte of the hunt.
                if (i_Frame_Ack) begin
                    if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) begin
                        w_next_state = S_CMD;
                    end else begin
                        w_next_state = S_HUNT;
                    end
                end else if (i_Rx_DV) begin
                    w_overrun = 1'b1;
                end
            end
            default: begin
                w_next_state = S_HUNT;
            end
        endcase

        if (w_in_frame && !i_Rx_DV) begin
            if (r_tcnt == TO_LAST) begin
                w_err_to     = 1'b1;
                w_next_state = S_HUNT;
            end else begin
                w_tcnt = r_tcnt + 1'b1;
            end
        end
    end

    frame_payload_ram #(
        .DEPTH  (MAX_LEN),
        .ADDR_W (ADDR_W)
    ) u_payload_ram (
        .clk     (i_Clock),
        .rst     (i_Reset),
        .wr_en   (w_wr_en),
        .wr_addr (r_idx[ADDR_W-1:0]),
        .wr_data (i_Rx_Byte),
        .rd_addr (i_Rd_Addr),
        .rd_data (o_Rd_Data)
    );

    assign o_Frame_Valid  = r_valid;
    assign o_Frame_Cmd    = r_cmd;
    assign o_Frame_Len    = r_len;
    assign o_Err_Checksum = r_err_chk;
    assign o_Err_Length   = r_err_len;
    assign o_Err_Timeout  = r_err_to;
    assign o_Overrun      = r_overrun;

endmodule : uart_frame_decoder
`default_nettype wire
